// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers
// for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One extra MSB distinguishes full from empty
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(
    input int width,
    input int depth,
    input int af,
    input int ae
  );
    return (width >= 1) &&
           (depth >= 4) &&
           is_pow2(depth) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// Register-array storage: synchronous write,
// asynchronous read. Contents are never reset.
module fifo_ram_sp
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill level, almost flags,
// sticky error flags and selectable read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = clog2(DEPTH),
  localparam int PW      = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR_W:0]  count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL))
  begin : g_bad_params
    $error("sync_fifo_param: illegal parameters");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  assign full         = (cnt_q == PW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= PW'(AF_LEVEL));
  assign almost_empty = (cnt_q <= PW'(AE_LEVEL));
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A same-cycle pop never makes room for a push
  assign wr_acc = wr_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case (1'b1)
      wr_acc && !rd_acc: cnt_d = cnt_q + PW'(1);
      !wr_acc && rd_acc: cnt_d = cnt_q - PW'(1);
      default:           cnt_d = cnt_q;
    endcase
  end

  // Set beats clear when both happen together
  always_comb begin
    ovf_d = (ovf_q && !clr_err) || (wr_en && full);
    udf_d = (udf_q && !clr_err) || (r_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

  a_cnt_ptr : assert property (
    @(posedge clk) disable iff (!rst_n)
    (cnt_q == PW'(wr_ptr_q - rd_ptr_q)) &&
    (cnt_q <= PW'(DEPTH))
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and
// FWFT instances checked against a queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  typedef logic [W-1:0] q_t[$];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr [2];
  logic         rd [2];
  logic         clr [2];
  logic [W-1:0] din [2];
  logic [W-1:0] dout [2];
  logic         full [2];
  logic         empty [2];
  logic         af [2];
  logic         ae [2];
  logic [3:0]   cnt [2];
  logic         ovf [2];
  logic         udf [2];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .FWFT(0),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr[0]), .data_in(din[0]),
    .r_en(rd[0]), .data_out(dout[0]),
    .full(full[0]), .empty(empty[0]),
    .almost_full(af[0]), .almost_empty(ae[0]),
    .count(cnt[0]),
    .overflow(ovf[0]), .underflow(udf[0]),
    .clr_err(clr[0])
  );

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .FWFT(1),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr[1]), .data_in(din[1]),
    .r_en(rd[1]), .data_out(dout[1]),
    .full(full[1]), .empty(empty[1]),
    .almost_full(af[1]), .almost_empty(ae[1]),
    .count(cnt[1]),
    .overflow(ovf[1]), .underflow(udf[1]),
    .clr_err(clr[1])
  );

  // Reference model
  q_t       mq0;
  q_t       mq1;
  logic [W-1:0] mdq = '0;
  bit       movf [2] = '{0, 0};
  bit       mudf [2] = '{0, 0};

  task automatic mstep(input int k, inout q_t q);
    bit f, e;
    f = (q.size() == D);
    e = (q.size() == 0);
    if (rd[k] && !e) begin
      if (k == 0) mdq = q.pop_front();
      else        void'(q.pop_front());
    end
    if (wr[k] && !f) q.push_back(din[k]);
    movf[k] = (movf[k] && !clr[k]) || (wr[k] && f);
    mudf[k] = (mudf[k] && !clr[k]) || (rd[k] && e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq0 = {};
      mq1 = {};
      mdq = '0;
      movf = '{0, 0};
      mudf = '{0, 0};
    end else begin
      mstep(0, mq0);
      mstep(1, mq1);
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               n, a, e);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [W-1:0] mout(input int k);
    if (k == 0) return mdq;
    return (mq1.size() == 0) ? '0 : mq1[0];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int s;
      s = msize(k);
      chk($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(s));
      chk($sformatf("full%0d", k), 32'(full[k]),
          32'(s == D));
      chk($sformatf("empty%0d", k), 32'(empty[k]),
          32'(s == 0));
      chk($sformatf("af%0d", k), 32'(af[k]),
          32'(s >= AF));
      chk($sformatf("ae%0d", k), 32'(ae[k]),
          32'(s <= AE));
      chk($sformatf("ovf%0d", k), 32'(ovf[k]),
          32'(movf[k]));
      chk($sformatf("udf%0d", k), 32'(udf[k]),
          32'(mudf[k]));
      chk($sformatf("dout%0d", k), 32'(dout[k]),
          32'(mout(k)));
    end
  end

  task automatic drive(input int k, input bit w,
                       input logic [W-1:0] d,
                       input bit r, input bit c);
    wr[k]  = w;
    din[k] = d;
    rd[k]  = r;
    clr[k] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int k, input bit w,
                     input logic [W-1:0] d,
                     input bit r, input bit c);
    drive(k, w, d, r, c);
    tick();
    drive(k, 0, '0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    drive(1, 0, '0, 0, 0);
    #2;
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_empty", 32'(empty[0]), 1);
    chk("rst_ae", 32'(ae[0]), 1);
    chk("rst_full", 32'(full[0]), 0);
    chk("rst_af", 32'(af[0]), 0);
    chk("rst_dout", 32'(dout[0]), 0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 8'h11 + 8'(i), 0, 0);
      if (i == 4) chk("af_at5", 32'(af[0]), 0);
      if (i == 5) chk("af_at6", 32'(af[0]), 1);
    end
    chk("fill_full", 32'(full[0]), 1);
    chk("fill_cnt", 32'(cnt[0]), 8);

    cyc(0, 1, 8'h99, 0, 0);
    chk("ovf_set", 32'(ovf[0]), 1);
    chk("ovf_cnt", 32'(cnt[0]), 8);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, '0, 1, 0);
      chk($sformatf("rd%0d", i), 32'(dout[0]),
          32'(8'h11 + 8'(i)));
    end
    chk("drain_empty", 32'(empty[0]), 1);

    cyc(0, 0, '0, 1, 0);
    chk("udf_set", 32'(udf[0]), 1);
    chk("udf_hold", 32'(dout[0]), 32'h18);
    chk("udf_cnt", 32'(cnt[0]), 0);
    cyc(0, 0, '0, 0, 1);
    chk("clr_udf", 32'(udf[0]), 0);
    chk("clr_ovf", 32'(ovf[0]), 0);
    cyc(0, 0, '0, 1, 1);
    chk("clr_vs_set", 32'(udf[0]), 1);
    cyc(0, 0, '0, 0, 1);

    for (int i = 0; i < 4; i++)
      cyc(0, 1, 8'hA0 + 8'(i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 8'h40 + 8'(i), 1, 0);
      chk("rw_cnt", 32'(cnt[0]), 4);
      chk($sformatf("rw%0d", i), 32'(dout[0]),
          (i < 4) ? 32'(8'hA0 + 8'(i))
                  : 32'(8'h40 + 8'(i - 4)));
    end

    for (int i = 0; i < 4; i++)
      cyc(0, 1, 8'hC0 + 8'(i), 0, 0);
    chk("refill_full", 32'(full[0]), 1);
    cyc(0, 1, 8'hEE, 1, 0);
    chk("fullrw_cnt", 32'(cnt[0]), 7);
    chk("fullrw_ovf", 32'(ovf[0]), 1);
    chk("fullrw_dout", 32'(dout[0]), 32'h50);

    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);
    chk("pre_rst_cnt", 32'(cnt[0]), 5);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt[0]), 0);
    chk("arst_empty", 32'(empty[0]), 1);
    chk("arst_ovf", 32'(ovf[0]), 0);
    chk("arst_dout", 32'(dout[0]), 0);
    tick();
    rst_n = 1'b1;
    cyc(0, 1, 8'h5A, 0, 0);
    cyc(0, 0, '0, 1, 0);
    chk("post_rst_rd", 32'(dout[0]), 32'h5A);
    chk("post_rst_empty", 32'(empty[0]), 1);

    cyc(1, 1, 8'hA5, 0, 0);
    chk("fwft_show", 32'(dout[1]), 32'hA5);
    chk("fwft_nempty", 32'(empty[1]), 0);
    cyc(1, 1, 8'h3C, 0, 0);
    chk("fwft_head", 32'(dout[1]), 32'hA5);
    cyc(1, 0, '0, 1, 0);
    chk("fwft_next", 32'(dout[1]), 32'h3C);
    cyc(1, 0, '0, 1, 0);
    chk("fwft_zero", 32'(dout[1]), 0);
    chk("fwft_empty", 32'(empty[1]), 1);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock FIFO, parametrised in data width, depth and read mode.
Adds fill level, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
Generalises the team's dual-pointer FIFO scheme (extra pointer MSB for wrap detection) into a reusable buffer between same-clock producer/consumer stages.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through (head word visible on data_out)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
Derived: ADDR_W = clog2(DEPTH); pointers and count are ADDR_W+1 bits.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
data_in  in  WIDTH  write data, sampled on accepted write
r_en  in  1  read/pop request
data_out  out  WIDTH  read data (meaning per FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current fill level, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr, count, data_out, overflow, underflow = 0; empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>=1). Memory contents not reset. Reset mid-operation discards all stored words.
- Accepted write: wr_en && !full -> mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr+1 at the edge.
- Accepted read: r_en && !empty -> rd_ptr+1 at the edge.
- Flags evaluated from registered state before the edge; a rejected request has no effect on pointers, memory or data_out.
- Simultaneous accepted read+write: both pointers advance, count unchanged. When full, write is rejected even if a read is accepted in the same cycle; when empty, read is rejected even if a write is accepted in the same cycle.
- count: +1 on write-only, -1 on read-only, hold otherwise; full/empty/almost_* decoded combinationally from registered count. Cross-check invariant: count == wr_ptr - rd_ptr (mod 2^(ADDR_W+1)).
- Wrap-around: pointers roll over at 2^(ADDR_W+1); the MSB differs when full with equal lower bits; transparent across wrap.
- Write-to-read latency: a word written at edge N makes empty=0 after edge N; readable from edge N+1.
- FWFT=0: data_out <= mem[rd_ptr] on accepted read (valid one cycle after the r_en edge); otherwise holds last value.
- FWFT=1: data_out = mem[rd_ptr] whenever !empty, 0 when empty; r_en pops the shown word and the next head appears after the edge.
- Errors: wr_en && full sets overflow; r_en && empty sets underflow. clr_err clears both at the next edge; a set event in the same cycle as clr_err wins (flag stays 1).

Decomposition:
- Shared package fifo_pkg: clog2 function; pointer-width helper; default width/depth constants.
- Package also holds a parameter sanity check: DEPTH power of two; AF_LEVEL/AE_LEVEL range check; elaboration error on violation.
- One sub-module: fifo_ram_sp, a WIDTH x DEPTH register array with synchronous write and asynchronous read port. Pointers, count, flags and read-mode muxing stay in sync_fifo_param.

Test Plan:
- WIDTH=8, DEPTH=8, FWFT=0: write 0x11..0x18 -> full=1, count=8, almost_full=1 from count 6. Ninth write 0x99 -> overflow=1, stored data unchanged. Read 8 -> data_out 0x11..0x18 each one cycle after r_en, then empty=1.
- Empty read: r_en with count=0 -> underflow=1, data_out holds, pointers unchanged. clr_err -> underflow=0 next cycle. clr_err with a simultaneous r_en on empty -> underflow stays 1.
- Simultaneous read+write at count=4 for 20 cycles -> count stays 4; output order matches input order across two pointer wraps.
- Full + simultaneous wr_en/r_en -> read accepted, write rejected, overflow=1, count=7.
- FWFT=1: write 0xA5 into empty FIFO -> data_out=0xA5 after the next edge without r_en. Pop -> data_out=0, empty=1.
- Assert rst_n low mid-stream at count=5 -> count=0, empty=1, flags cleared immediately without a clock edge. Subsequent write/read returns new data only.
